// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM for SB_RGBA_DRV: pwm_x registered one clock after phase; staged duties commit at a period
// boundary and wr_ready stays low while a commit is pending. Define RGB_PWM_FADE_EN to ramp active by one step per period.
module rgb_pwm_gen #(
   parameter int PRESCALE = 94,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [1:0]       wr_sel,
   input  logic [CNT_W-1:0] wr_duty,
   input  logic             wr_commit,
   output logic             pwm_r,
   output logic             pwm_g,
   output logic             pwm_b,
   output logic             period_start,
   output logic             pending
);
   localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] PH_MAX  = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    pre, pre_nxt, pre_inc;
   logic [CNT_W-1:0] phase, phase_nxt, phase_inc;
   logic             tick, boundary, commit_ok, accept, done;
   logic [CNT_W-1:0] staging    [3];
   logic [CNT_W-1:0] active     [3];
   logic [CNT_W-1:0] active_nxt [3];
   logic [2:0]       pwm;

   assign tick      = (pre == PRE_MAX);
   assign boundary  = tick && (phase == PH_MAX);
   assign pre_inc   = tick ? '0 : pre + PW'(1);
   assign phase_inc = tick ? phase + CNT_W'(1) : phase;
   assign wr_ready  = !pending;
   assign accept    = wr_valid && wr_ready;
   assign pwm_r     = pwm[0];
   assign pwm_g     = pwm[1];
   assign pwm_b     = pwm[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // While idle the period boundary is considered always reached, so commits land immediately.
   always_comb begin
      state_nxt = state;
      pre_nxt   = '0;
      phase_nxt = '0;
      commit_ok = 1'b0;
      case (state)
         IDLE: begin
            commit_ok = 1'b1;
            if (enable) begin
               state_nxt = RUN;
               pre_nxt   = pre_inc;
               phase_nxt = phase_inc;
            end
         end
         RUN: begin
            commit_ok = boundary;
            if (enable) begin
               pre_nxt   = pre_inc;
               phase_nxt = phase_inc;
            end else begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

`ifdef RGB_PWM_FADE_EN
   always_comb begin
      done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         active_nxt[i] = active[i];
         if (active[i] < staging[i])      active_nxt[i] = active[i] + CNT_W'(1);
         else if (active[i] > staging[i]) active_nxt[i] = active[i] - CNT_W'(1);
         if (active_nxt[i] != staging[i]) done = 1'b0;
      end
   end
`else
   always_comb begin
      done = 1'b1;
      for (int i = 0; i < 3; i++) active_nxt[i] = staging[i];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre          <= '0;
         phase        <= '0;
         pending      <= 1'b0;
         period_start <= 1'b0;
         pwm          <= '0;
         for (int i = 0; i < 3; i++) begin
            staging[i] <= '0;
            active[i]  <= '0;
         end
      end else begin
         pre          <= pre_nxt;
         phase        <= phase_nxt;
         period_start <= enable && boundary;
         for (int i = 0; i < 3; i++) begin
            pwm[i] <= enable && (phase < active[i]);
            if (accept && (wr_sel == 2'(i) || wr_sel == 2'd3))
               staging[i] <= wr_duty;
         end
         // Writes are blocked while pending, so a commit and a new commit write never coincide.
         if (commit_ok && pending) begin
            for (int i = 0; i < 3; i++) active[i] <= active_nxt[i];
            if (done) pending <= 1'b0;
         end else if (accept && wr_commit) begin
            pending <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Directed bench for rgb_pwm_gen with PRESCALE=2 (512-clock period); expectations queued then popped at each check.
module tb_rgb_pwm_gen;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_commit = 1'b0;
   logic [1:0] wr_sel = 2'd0;
   logic [7:0] wr_duty = 8'd0;
   logic       wr_ready, pwm_r, pwm_g, pwm_b, period_start, pending;

   int    nvec = 0;
   int    nfail = 0;
   int    exp_q[$];
   string tag_q[$];

   always #5 clk = ~clk;

   rgb_pwm_gen #(.PRESCALE(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
      .wr_duty(wr_duty), .wr_commit(wr_commit),
      .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
      .period_start(period_start), .pending(pending)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void push(input string t, input int v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endfunction

   task automatic check(input int obs);
      string t;
      int    e;
      if (exp_q.size() == 0) begin
         nfail++;
         $error("FAIL scoreboard_empty observed %0d", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         nvec++;
         assert (obs === e) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
         end
      end
   endtask

   task automatic wait_ps(output int n, output int found, output int r_hi);
      n = 0; found = 0; r_hi = 0;
      while (found == 0 && n < 1100) begin
         step();
         n++;
         if (pwm_r) r_hi++;
         if (period_start) found = 1;
      end
   endtask

   task automatic measure(output int r, output int g, output int b, output int pc, output int pl);
      r = 0; g = 0; b = 0; pc = 0;
      for (int i = 0; i < 512; i++) begin
         step();
         if (pwm_r) r++;
         if (pwm_g) g++;
         if (pwm_b) b++;
         if (period_start) pc++;
      end
      pl = int'(period_start);
   endtask

   task automatic period_check(input string t, input int er, input int eg, input int eb);
      int r, g, b, pc, pl;
      push({t, "_r_hi"}, er); push({t, "_g_hi"}, eg); push({t, "_b_hi"}, eb);
      push({t, "_ps_cnt"}, 1); push({t, "_ps_end"}, 1);
      measure(r, g, b, pc, pl);
      check(r); check(g); check(b); check(pc); check(pl);
   endtask

   task automatic write(input logic [1:0] sel, input logic [7:0] duty, input logic commit, output int waited);
      wr_valid = 1'b1; wr_sel = sel; wr_duty = duty; wr_commit = commit;
      waited = 0;
      while (!wr_ready && waited < 1100) begin
         step();
         waited++;
      end
      step();
      wr_valid = 1'b0;
      wr_commit = 1'b0;
   endtask

   initial begin
      int n, found, rh, w;

      push("rst_pwm", 0); push("rst_ps", 0); push("rst_pend", 0); push("rst_rdy", 1);
      #12;
      check(int'({pwm_r, pwm_g, pwm_b})); check(int'(period_start));
      check(int'(pending)); check(int'(wr_ready));
      step();
      rst_n = 1'b1;
      enable = 1'b1;

      // Free run with zero duties
      push("first_ps_lat", 512);
      wait_ps(n, found, rh);
      check(n);
      period_check("zero_duty", 0, 0, 0);
      push("run_rdy", 1);
      check(int'(wr_ready));

      // Staged R, committed with G
      write(2'd0, 8'd64, 1'b0, w);
      write(2'd1, 8'd128, 1'b1, w);
      push("rg_pend", 1); push("rg_rdy", 0);
      check(int'(pending)); check(int'(wr_ready));
      push("rg_found", 1); push("rg_pend_clr", 0);
      wait_ps(n, found, rh);
      check(found); check(int'(pending));
      period_check("rg", 128, 256, 0);

      // All channels full and off
      write(2'd3, 8'd255, 1'b1, w);
      push("full_found", 1);
      wait_ps(n, found, rh);
      check(found);
      period_check("full", 510, 510, 510);
      write(2'd3, 8'd0, 1'b1, w);
      push("off_found", 1);
      wait_ps(n, found, rh);
      check(found);
      period_check("off", 0, 0, 0);

      // Commit write landing on the boundary cycle, then a blocked second write
      repeat (511) step();
      write(2'd0, 8'd100, 1'b1, w);
      push("coll_ps", 1); push("coll_pend", 1); push("coll_rdy", 0);
      check(int'(period_start)); check(int'(pending)); check(int'(wr_ready));
      push("blocked_wait", 512);
      write(2'd2, 8'd10, 1'b1, w);
      check(w);
      push("second_pend", 1); push("second_found", 1);
      check(int'(pending));
      wait_ps(n, found, rh);
      check(found);
      period_check("coll", 200, 0, 20);

      // Disable mid-period, commit while idle, re-enable
      repeat (100) step();
      push("mid_r", 1);
      check(int'(pwm_r));
      enable = 1'b0;
      step();
      push("dis_pwm", 0); push("dis_ps", 0);
      check(int'({pwm_r, pwm_g, pwm_b})); check(int'(period_start));
      write(2'd0, 8'd32, 1'b1, w);
      push("idle_pend_set", 1);
      check(int'(pending));
      step();
      push("idle_pend_clr", 0);
      check(int'(pending));
      enable = 1'b1;
      push("reen_lat", 512); push("reen_r_hi", 64);
      wait_ps(n, found, rh);
      check(n); check(rh);
      period_check("reen", 64, 0, 20);

      // Reset while a commit is pending
      write(2'd3, 8'd200, 1'b1, w);
      push("pre_rst_r", 1); push("pre_rst_pend", 1);
      check(int'(pwm_r)); check(int'(pending));
      #2;
      rst_n = 1'b0;
      #1;
      push("mrst_pwm", 0); push("mrst_pend", 0); push("mrst_rdy", 1); push("mrst_ps", 0);
      check(int'({pwm_r, pwm_g, pwm_b})); check(int'(pending));
      check(int'(wr_ready)); check(int'(period_start));
      step();
      rst_n = 1'b1;
      push("post_rst_lat", 512); push("post_rst_r_hi", 0);
      wait_ps(n, found, rh);
      check(n); check(rh);
      period_check("post_rst", 0, 0, 0);

      // Commit 0 -> 4 on R
      write(2'd0, 8'd4, 1'b1, w);
      push("ramp_found", 1);
      wait_ps(n, found, rh);
      check(found);
`ifdef RGB_PWM_FADE_EN
      push("fade_pend1", 1);
      check(int'(pending));
      period_check("fade1", 2, 0, 0);
      push("fade_pend2", 1);
      check(int'(pending));
      period_check("fade2", 4, 0, 0);
      push("fade_pend3", 1);
      check(int'(pending));
      period_check("fade3", 6, 0, 0);
      push("fade_pend4", 0);
      check(int'(pending));
      period_check("fade4", 8, 0, 0);
`else
      push("jump_pend", 0);
      check(int'(pending));
      period_check("jump", 8, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/rgb_pwm_gen.md
Name: rgb_pwm_gen

Overview:
- Three-channel PWM generator feeding the RGB0PWM/RGB1PWM/RGB2PWM inputs of the SB_RGBA_DRV hard LED driver on the iCE40UP5K.
- Replaces the tied-off constant PWM levels with programmable 8-bit duty cycles.
- Duty values are written by the ESP32-side register logic into staging registers, then committed glitch-free at a PWM period boundary.

Parameters:
- PRESCALE, 94, system clocks per PWM phase step (>=1). At 48 MHz this gives a PWM period of 94*256 clocks, about 1.99 kHz.
- CNT_W, 8, phase counter and duty width. Period is 2^CNT_W phase steps.

Ports:
- clk  input  1  system clock (48 MHz HFOSC)
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run PWM; low forces outputs low and holds the counters
- wr_valid  input  1  write request
- wr_ready  output  1  write accepted when wr_valid && wr_ready
- wr_sel  input  2  0=R (RGB0), 1=G (RGB1), 2=B (RGB2), 3=all three
- wr_duty  input  CNT_W  duty value written to staging
- wr_commit  input  1  with an accepted write: request staging->active transfer
- pwm_r  output  1  to RGB0PWM
- pwm_g  output  1  to RGB1PWM
- pwm_b  output  1  to RGB2PWM
- period_start  output  1  one-cycle pulse when the phase wraps to 0
- pending  output  1  commit requested, not yet applied

Behaviour:
- Reset (async, rst_n=0):
  - prescaler, phase, staging and active registers = 0
  - pwm_r/g/b = 0, period_start = 0, pending = 0, wr_ready = 1
- Prescaler:
  - counts 0..PRESCALE-1
  - tick = (prescaler == PRESCALE-1)
  - wraps to 0 on tick
- Phase:
  - increments on tick, wraps 2^CNT_W-1 -> 0
  - boundary = tick && phase == 2^CNT_W-1
- Outputs:
  - pwm_x registered: pwm_x <= enable && (phase < active_x), one clock after phase update
  - duty 0 = constant low; duty 255 = high 255 of 256 steps (never fully on)
- period_start: registered pulse on the cycle after boundary, only while enable=1.
- Write handshake:
  - wr_ready = !pending
  - Accepted write: staging[wr_sel] <= wr_duty; sel=3 writes all three.
  - Accepted write with wr_commit=1 sets pending.
  - Writes while pending=1 are not accepted; the writer holds wr_valid.
- Commit:
  - At boundary with pending=1: active <= staging (all three in the same cycle), pending <= 0, so wr_ready=1 the next cycle.
- Write/boundary collision: a commit write accepted on the boundary cycle updates staging and sets pending, but is applied at the next boundary, not the current one.
- State machine:
  - IDLE (enable=0): prescaler=phase=0, outputs 0. A commit is applied on the cycle after pending is set (boundary is treated as always true).
  - RUN (enable=1): normal counting.
  - IDLE->RUN on enable rise: counting starts from phase 0 and period_start pulses after the first full period.
  - RUN->IDLE on enable fall: counters cleared next cycle, outputs low next cycle. Staging, active and pending are retained.
- Reset mid-operation: immediate return to reset values. Any pending commit is lost.

Optional Feature:
- Macro: RGB_PWM_FADE_EN
- With the macro:
  - Each boundary with pending=1 moves every active_x one step toward staging_x (+1 or -1, unchanged if equal).
  - pending clears only at the boundary where all three active values equal staging. wr_ready stays low until then.
  - A full 0->255 fade takes 255 periods.
  - IDLE behaviour is unchanged (fade steps once per cycle while pending).
- Without the macro: active jumps directly to staging at the first boundary.

Test Plan:
- Reset release, enable=1, PRESCALE=2, no writes -> pwm_r/g/b stay 0. period_start pulses every 512 clocks. wr_ready=1.
- Write sel=0 duty 64, then sel=1 duty 128 with commit -> pending=1, wr_ready=0. Next boundary: pwm_r high 128 clocks and pwm_g high 256 clocks of each 512-clock period. pwm_b=0.
- sel=3 duty 255 with commit -> all outputs high 510 of 512 clocks. sel=3 duty 0 with commit -> all outputs constant low after the next boundary.
- Commit write presented on the exact boundary cycle -> applied one period later. A second write while pending=1 sees wr_ready=0 and is accepted only after pending clears.
- enable=0 mid-period -> outputs 0 and phase=0 next cycle. A commit of duty 32 applies within 2 cycles. enable=1 -> pwm_r high 64 clocks per period from phase 0.
- Assert rst_n=0 mid-period while pending=1 -> all outputs 0 and pending=0 immediately. With RGB_PWM_FADE_EN: committing 0->4 gives active 1, 2, 3, 4 over 4 boundaries and pending clears at the 4th.
